trig_delay_meas: RTL and testbench

- Loop-back latency meter for the trigger path.
- Issues one trigger pulse on request, watches the returned trigger, and reports the clock-cycle latency between them.
- Sits on the receiving end of a trigger delay stage; used for calibrating and checking programmed trigger delays over the SFP link.
- Also keeps a running maximum of the measured delays and a count of stray return pulses.

---
 rtl/trig_delay_meas.sv | 122 ++++++++++++
 tb/tb_trig_delay_meas.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/trig_delay_meas.sv
// Trigger loop-back latency meter: issues one trigger per arm request, times the
// returned edge in clock cycles, and keeps a running maximum and stray-return count.
module trig_delay_meas #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255,
  parameter int STRAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               clr_stats,
  input  logic               trig_return,
  output logic               trig_send,
  output logic               busy,
  output logic [CNT_W-1:0]   meas_delay,
  output logic               meas_valid,
  output logic               meas_timeout,
  output logic [CNT_W-1:0]   meas_max,
  output logic [STRAY_W-1:0] stray_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               ret_d;
  logic               ret_rise;
  logic               good;
  logic               tmo;
  logic               stray;

  // A held-high return line must only count once, so everything keys off the rising edge.
  assign ret_rise = trig_return & ~ret_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ret_d        <= 1'b0;
      meas_delay   <= '0;
      meas_valid   <= 1'b0;
      meas_timeout <= 1'b0;
      meas_max     <= '0;
      stray_cnt    <= '0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      ret_d        <= trig_return;
      meas_valid   <= good;
      meas_timeout <= tmo;

      if (good)
        meas_delay <= cnt;
      else if (tmo)
        meas_delay <= '1;

      // The clear takes priority over a result landing on the same edge.
      if (clr_stats)
        meas_max <= '0;
      else if (good && (cnt > meas_max))
        meas_max <= cnt;

      if (clr_stats)
        stray_cnt <= '0;
      else if (stray && (stray_cnt != '1))
        stray_cnt <= stray_cnt + STRAY_W'(1);
    end
  end

  // The counter is zero whenever the FSM leaves WAIT, so SEND always sees cnt == 0.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    good       = 1'b0;
    tmo        = 1'b0;
    stray      = 1'b0;
    trig_send  = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        stray    = ret_rise;
        if (arm)
          state_next = SEND;
      end
      SEND: begin
        trig_send = 1'b1;
        busy      = 1'b1;
        if (ret_rise) begin
          good       = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next   = CNT_W'(1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (ret_rise) begin
          good       = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          tmo        = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_trig_delay_meas.sv
// Directed bench for trig_delay_meas: loop-back returns at chosen latencies, timeouts,
// stray returns, statistics clearing and reset during a measurement.
module tb_trig_delay_meas;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       clr_stats = 1'b0;
  logic       trig_return = 1'b0;
  logic       trig_send;
  logic       busy;
  logic [7:0] meas_delay;
  logic       meas_valid;
  logic       meas_timeout;
  logic [7:0] meas_max;
  logic [7:0] stray_cnt;

  int vectors = 0;
  int miscompares = 0;

  trig_delay_meas #(.CNT_W(8), .TIMEOUT(20), .STRAY_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .clr_stats    (clr_stats),
    .trig_return  (trig_return),
    .trig_send    (trig_send),
    .busy         (busy),
    .meas_delay   (meas_delay),
    .meas_valid   (meas_valid),
    .meas_timeout (meas_timeout),
    .meas_max     (meas_max),
    .stray_cnt    (stray_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge, clear of the active edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Arm once and raise the return n cycles after the trig_send cycle; returns in the result cycle.
  task automatic apply_stimulus(input int n, input bit hold, input logic [7:0] exp_max);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_output("send_pulse", trig_send, 1);
    check_output("send_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      tick();
      check_output("wait_no_send", trig_send, 0);
      check_output("wait_busy", busy, 1);
      check_output("wait_no_valid", meas_valid, 0);
    end
    trig_return = 1'b1;
    tick();
    check_output("result_valid", meas_valid, 1);
    check_output("result_no_tmo", meas_timeout, 0);
    check_output("result_delay", meas_delay, n);
    check_output("result_busy", busy, 0);
    check_output("result_max", meas_max, exp_max);
    if (!hold)
      trig_return = 1'b0;
    tick();
    check_output("valid_one_cycle", meas_valid, 0);
  endtask

  task automatic stray_pulse();
    trig_return = 1'b1;
    tick();
    trig_return = 1'b0;
    tick();
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check_output("clr_max", meas_max, 0);
    check_output("clr_stray", stray_cnt, 0);
  endtask

  initial begin
    tick();
    tick();
    check_output("rst_send", trig_send, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_valid", meas_valid, 0);
    check_output("rst_tmo", meas_timeout, 0);
    check_output("rst_delay", meas_delay, 0);
    check_output("rst_max", meas_max, 0);
    check_output("rst_stray", stray_cnt, 0);
    rst = 1'b0;
    tick();

    $display("[TB] loop-back at 5 cycles");
    apply_stimulus(5, 1'b0, 8'd5);

    $display("[TB] held return from the send cycle, then 3 cycles");
    apply_stimulus(0, 1'b1, 8'd5);
    repeat (4) tick();
    check_output("held_no_stray", stray_cnt, 0);
    trig_return = 1'b0;
    tick();
    apply_stimulus(3, 1'b0, 8'd5);
    check_output("held_stray_after", stray_cnt, 0);

    $display("[TB] timeout after 20 cycles");
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check_output("tmo_not_yet", meas_timeout, 0);
    end
    tick();
    check_output("tmo_strobe", meas_timeout, 1);
    check_output("tmo_no_valid", meas_valid, 0);
    check_output("tmo_delay", meas_delay, 8'hFF);
    check_output("tmo_max", meas_max, 5);
    check_output("tmo_busy", busy, 0);
    tick();
    check_output("tmo_one_cycle", meas_timeout, 0);

    $display("[TB] running maximum and clear");
    apply_stimulus(9, 1'b0, 8'd9);
    apply_stimulus(4, 1'b0, 8'd9);
    check_output("max_delay_4", meas_delay, 4);
    clear_stats();

    $display("[TB] return coinciding with the timeout count");
    apply_stimulus(20, 1'b0, 8'd20);

    $display("[TB] stray returns while idle");
    repeat (3) stray_pulse();
    check_output("stray_3", stray_cnt, 3);
    repeat (300) stray_pulse();
    check_output("stray_sat", stray_cnt, 255);
    clear_stats();

    $display("[TB] arm and stray edge in the same cycle");
    arm = 1'b1;
    trig_return = 1'b1;
    tick();
    arm = 1'b0;
    trig_return = 1'b0;
    check_output("both_send", trig_send, 1);
    check_output("both_stray", stray_cnt, 1);
    tick();
    tick();
    trig_return = 1'b1;
    tick();
    trig_return = 1'b0;
    check_output("both_valid", meas_valid, 1);
    check_output("both_delay", meas_delay, 2);
    check_output("both_max", meas_max, 2);
    check_output("both_stray_kept", stray_cnt, 1);
    tick();

    $display("[TB] arm while busy is ignored");
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_output("busy_arm_send", trig_send, 1);
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_output("busy_arm_no_send", trig_send, 0);
    tick();
    trig_return = 1'b1;
    tick();
    trig_return = 1'b0;
    check_output("busy_arm_valid", meas_valid, 1);
    check_output("busy_arm_delay", meas_delay, 3);
    tick();
    check_output("busy_arm_not_queued", trig_send, 0);
    check_output("busy_arm_idle", busy, 0);

    $display("[TB] reset during WAIT");
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort_busy", busy, 0);
    check_output("abort_send", trig_send, 0);
    check_output("abort_valid", meas_valid, 0);
    check_output("abort_tmo", meas_timeout, 0);
    check_output("abort_delay", meas_delay, 0);
    check_output("abort_max", meas_max, 0);
    check_output("abort_stray", stray_cnt, 0);
    trig_return = 1'b1;
    tick();
    trig_return = 1'b0;
    check_output("abort_ret_valid", meas_valid, 0);
    check_output("abort_ret_stray", stray_cnt, 1);
    for (int i = 0; i < 25; i++) begin
      tick();
      check_output("abort_no_strobe", {meas_valid, meas_timeout}, 2'b00);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
